// File: rtl/rec_pkg.sv
// -----------------------------------------------------------------------------
// rec_pkg
// Shared definitions for the recording controller: FSM state encoding and the
// all-lanes byte write-enable constant.
// No ports (package).
// -----------------------------------------------------------------------------
package rec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_REC  = 2'd2,
    ST_DONE = 2'd3
  } rec_state_e;

  // Wide enough for any sensible DATA_W; users slice the low WE_W bits.
  localparam int              WE_MAX = 64;
  localparam logic [WE_MAX-1:0] WE_ALL = '1;

endpackage

// File: rtl/rec_capture_ctrl_if.sv
// -----------------------------------------------------------------------------
// rec_capture_ctrl_if
// Bundles the control inputs, the deserializer word stream, the BRAM write
// port and the status outputs of rec_capture_ctrl.
//   master : drives start/stop/loop_mode/word_valid/word_data, observes the rest
//   slave  : the controller side (receives requests/words, drives BRAM + status)
// -----------------------------------------------------------------------------
interface rec_capture_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  localparam int WE_W = DATA_W / 8;

  logic              start;
  logic              stop;
  logic              loop_mode;
  logic              word_valid;
  logic [DATA_W-1:0] word_data;
  logic [WE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              busy;
  logic              done;
  logic              wrapped;
  logic [ADDR_W:0]   rec_len;

  modport master (
    output start, stop, loop_mode, word_valid, word_data,
    input  mem_we, mem_addr, mem_din, busy, done, wrapped, rec_len
  );

  modport slave (
    input  start, stop, loop_mode, word_valid, word_data,
    output mem_we, mem_addr, mem_din, busy, done, wrapped, rec_len
  );

endinterface

// File: rtl/rec_addr_gen.sv
// -----------------------------------------------------------------------------
// rec_addr_gen
// Write-address counter for the recorder. Wraps from DEPTH-1 back to 0,
// keeps a saturating word count (ADDR_W+1 bits so DEPTH = 2**ADDR_W fits)
// and a sticky wrapped flag that only sets in loop mode.
//   clk, reset : clock, asynchronous active-high reset
//   i_clear    : zero address, count and wrapped (new recording)
//   i_inc      : one word is being written at o_addr this cycle
//   i_loop     : circular mode; enables the wrapped flag
//   o_addr     : current write address
//   o_count    : words written, saturating at DEPTH
//   o_wrapped  : address has wrapped in loop mode
// -----------------------------------------------------------------------------
module rec_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 937
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_inc,
  input  logic              i_loop,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W:0]   o_count,
  output logic              o_wrapped
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_wrapped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_clear) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
    end else if (i_inc) begin
      if (r_addr == LAST_ADDR) begin
        r_addr <= '0;
        if (i_loop) begin
          r_wrapped <= 1'b1;
        end
      end else begin
        r_addr <= r_addr + 1'b1;
      end
      if (r_count != FULL_LEN) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_addr    = r_addr;
  assign o_count   = r_count;
  assign o_wrapped = r_wrapped;

endmodule

// File: rtl/rec_capture_ctrl.sv
// -----------------------------------------------------------------------------
// rec_capture_ctrl
// Recording controller between the microphone deserializer and the sample
// BRAM write port. Single-shot or circular recording, early stop, done pulse,
// final-length report and wrapped flag. All outputs are registered.
//   clk, reset     : clock, asynchronous active-high reset
//   bus.start      : record request (ignored unless idle; beats stop)
//   bus.stop       : early stop request (ARM/REC only)
//   bus.loop_mode  : 0 single-shot, 1 circular; latched on start
//   bus.word_valid : word_data holds a complete word this cycle
//   bus.word_data  : deserialized sample word
//   bus.mem_we     : byte write enables, one cycle per accepted word
//   bus.mem_addr   : BRAM write address
//   bus.mem_din    : BRAM write data
//   bus.busy       : high in ARM or REC
//   bus.done       : one-cycle pulse at end of recording
//   bus.wrapped    : loop mode wrapped past the last address
//   bus.rec_len    : valid words in memory after the last recording
// -----------------------------------------------------------------------------
module rec_capture_ctrl
  import rec_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 10,
  parameter  int DEPTH  = 937,
  localparam int WE_W   = DATA_W / 8
) (
  input  logic                clk,
  input  logic                reset,
  rec_capture_ctrl_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W + 1)'(DEPTH);
  localparam logic [WE_W-1:0]   WE_LANES  = WE_ALL[WE_W-1:0];

  rec_state_e        r_state;
  rec_state_e        w_state_next;

  logic              r_loop;
  logic [WE_W-1:0]   r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   r_rec_len;

  logic [WE_W-1:0]   w_mem_we_next;
  logic [ADDR_W-1:0] w_mem_addr_next;
  logic [DATA_W-1:0] w_mem_din_next;
  logic              w_busy_next;
  logic              w_done_next;
  logic [ADDR_W:0]   w_rec_len_next;

  logic              w_clear;
  logic              w_inc;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W:0]   w_count;
  logic              w_wrapped;

  // Only an idle controller accepts start; this also makes start beat stop.
  assign w_clear = (r_state == ST_IDLE) && bus.start;
  // The arming word is swallowed: only words seen in REC are written.
  assign w_inc   = (r_state == ST_REC) && bus.word_valid;
  // Single-shot ends on the very write that targets the last address.
  assign w_last  = w_inc && !r_loop && (w_addr == LAST_ADDR);

  rec_addr_gen #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_inc     (w_inc),
    .i_loop    (r_loop),
    .o_addr    (w_addr),
    .o_count   (w_count),
    .o_wrapped (w_wrapped)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_ARM;
      ST_ARM: begin
        if (bus.stop)            w_state_next = ST_DONE;
        else if (bus.word_valid) w_state_next = ST_REC;
      end
      ST_REC:  if (w_last || bus.stop) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output next-value logic
  always_comb begin
    w_mem_we_next   = w_inc ? WE_LANES : '0;
    w_mem_addr_next = w_inc ? w_addr : r_mem_addr;
    w_mem_din_next  = w_inc ? bus.word_data : r_mem_din;
    w_busy_next     = (w_state_next == ST_ARM) || (w_state_next == ST_REC);
    w_done_next     = (r_state == ST_DONE);
    w_rec_len_next  = r_rec_len;
    if (w_clear) begin
      w_rec_len_next = '0;
    end else if (r_state == ST_DONE) begin
      // Count has settled by the DONE cycle, including a stop-cycle word.
      w_rec_len_next = w_wrapped ? FULL_LEN : w_count;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loop     <= 1'b0;
      r_mem_we   <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rec_len  <= '0;
    end else begin
      if (w_clear) begin
        r_loop <= bus.loop_mode;
      end
      r_mem_we   <= w_mem_we_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_din  <= w_mem_din_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_rec_len  <= w_rec_len_next;
    end
  end

  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.wrapped  = w_wrapped;
  assign bus.rec_len  = r_rec_len;

endmodule

// File: tb/tb_rec_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rec_capture_ctrl
// Directed bench for rec_capture_ctrl at DEPTH=8, ADDR_W=3, DATA_W=32.
// A recording-level model predicts each BRAM write (address, data, cycle) and
// each done pulse with its rec_len/wrapped; a negedge process compares the DUT
// against it every cycle. Literal checks pin memory contents and counts.
// -----------------------------------------------------------------------------
module tb_rec_capture_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic clk;
  logic reset;

  rec_capture_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rec_capture_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] shadow [0:DEPTH-1];
  int          wr_count   = 0;
  int          done_count = 0;

  // Recording-level model state
  bit m_active = 0;
  bit m_armed  = 0;
  bit m_loop   = 0;
  int m_n      = 0;
  int m_len    = 0;
  bit m_wrap   = 0;
  int exp_done_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Recording ends: done appears two edges after the inputs are applied.
  task automatic model_finish();
    m_active     = 0;
    m_len        = (m_n >= DEPTH) ? DEPTH : m_n;
    m_wrap       = m_loop && (m_n >= DEPTH);
    exp_done_cyc = cyc + 2;
  endtask

  task automatic model_start(input bit lp);
    if (!m_active) begin
      m_active = 1;
      m_armed  = 0;
      m_loop   = lp;
      m_n      = 0;
    end
  endtask

  task automatic model_word(input logic [31:0] d, input bit s);
    wr_t w;
    if (!m_active) return;
    if (!m_armed) begin
      if (s) model_finish();
      else   m_armed = 1;
      return;
    end
    w.addr = m_n % DEPTH;
    w.data = d;
    w.due  = cyc + 1;
    exp_q.push_back(w);
    m_n++;
    if (s || (!m_loop && m_n == DEPTH)) model_finish();
  endtask

  task automatic model_stop();
    if (m_active) model_finish();
  endtask

  // Compare process
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL write_missing: got none want addr %0d data 0x%0h at cycle %0d",
                 exp_q[0].addr, exp_q[0].data, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (bus.mem_we !== 4'h0) begin
        total++;
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          bad++;
          $display("FAIL unexpected_write: got we 0x%0h addr %0d data 0x%0h at cycle %0d want no write",
                   bus.mem_we, bus.mem_addr, bus.mem_din, cyc);
        end else begin
          if (bus.mem_we !== 4'hF || int'(bus.mem_addr) != exp_q[0].addr ||
              bus.mem_din !== exp_q[0].data) begin
            bad++;
            $display("FAIL write: got we 0x%0h addr %0d data 0x%0h want we 0xf addr %0d data 0x%0h",
                     bus.mem_we, bus.mem_addr, bus.mem_din, exp_q[0].addr, exp_q[0].data);
          end
          void'(exp_q.pop_front());
        end
        $display("write cycle %0d: addr %0d data 0x%0h", cyc, bus.mem_addr, bus.mem_din);
        shadow[bus.mem_addr] = bus.mem_din;
        wr_count++;
      end
      check("done_pulse", 64'(bus.done), 64'(cyc == exp_done_cyc));
      if (bus.done === 1'b1 && cyc == exp_done_cyc) begin
        check("done_rec_len", 64'(bus.rec_len), 64'(m_len));
        check("done_wrapped", 64'(bus.wrapped), 64'(m_wrap));
        $display("done cycle %0d: rec_len %0d wrapped %0d", cyc, bus.rec_len, bus.wrapped);
      end
      if (bus.done === 1'b1) done_count++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input bit lp, input bit with_stop);
    bus.start     = 1'b1;
    bus.loop_mode = lp;
    bus.stop      = with_stop;
    model_start(lp);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] d, input bit with_stop);
    bus.word_valid = 1'b1;
    bus.word_data  = d;
    bus.stop       = with_stop;
    model_word(d, with_stop);
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    bus.stop       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    model_stop();
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int w0;
  int d0;

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.loop_mode  = 1'b0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_we",   64'(bus.mem_we),   64'h0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    check("rst_mem_din",  64'(bus.mem_din),  64'h0);
    check("rst_busy",     64'(bus.busy),     64'h0);
    check("rst_done",     64'(bus.done),     64'h0);
    check("rst_wrapped",  64'(bus.wrapped),  64'h0);
    check("rst_rec_len",  64'(bus.rec_len),  64'h0);
    reset = 1'b0;
    idle(2);

    // Single-shot: A0 arms, A1..A8 land at 0..7
    w0 = wr_count; d0 = done_count;
    do_start(1'b0, 1'b0);
    check("ss_busy", 64'(bus.busy), 64'h1);
    for (int i = 0; i < 9; i++) strobe(32'hA0 + 32'(i), 1'b0);
    idle(2);
    check("ss_rec_len", 64'(bus.rec_len), 64'd8);
    check("ss_wrapped", 64'(bus.wrapped), 64'h0);
    check("ss_busy_end", 64'(bus.busy), 64'h0);
    check("ss_writes", 64'(wr_count - w0), 64'd8);
    check("ss_dones", 64'(done_count - d0), 64'd1);
    check("ss_mem0", 64'(shadow[0]), 64'hA1);
    check("ss_mem7", 64'(shadow[7]), 64'hA8);

    // Early stop together with the 4th word
    w0 = wr_count; d0 = done_count;
    do_start(1'b0, 1'b0);
    strobe(32'hC0, 1'b0);
    for (int i = 1; i < 4; i++) strobe(32'hC0 + 32'(i), 1'b0);
    strobe(32'hC4, 1'b1);
    idle(2);
    check("es_rec_len", 64'(bus.rec_len), 64'd4);
    check("es_writes", 64'(wr_count - w0), 64'd4);
    check("es_dones", 64'(done_count - d0), 64'd1);
    check("es_mem3", 64'(shadow[3]), 64'hC4);

    // Loop: 11 words, addresses 0..7,0,1,2
    w0 = wr_count;
    do_start(1'b1, 1'b0);
    strobe(32'hB0, 1'b0);
    for (int i = 1; i <= 11; i++) strobe(32'hB0 + 32'(i), 1'b0);
    pulse_stop();
    idle(2);
    check("lp_rec_len", 64'(bus.rec_len), 64'd8);
    check("lp_wrapped", 64'(bus.wrapped), 64'h1);
    check("lp_writes", 64'(wr_count - w0), 64'd11);
    check("lp_mem0", 64'(shadow[0]), 64'hB9);
    check("lp_mem1", 64'(shadow[1]), 64'hBA);
    check("lp_mem2", 64'(shadow[2]), 64'hBB);
    check("lp_mem3", 64'(shadow[3]), 64'hB4);

    // Ignored inputs
    d0 = done_count;
    pulse_stop();
    idle(3);
    check("ign_stop_done", 64'(done_count - d0), 64'd0);
    check("ign_hold_len", 64'(bus.rec_len), 64'd8);
    check("ign_hold_wrap", 64'(bus.wrapped), 64'h1);
    w0 = wr_count;
    strobe(32'h55, 1'b0);
    idle(2);
    check("ign_idle_word", 64'(wr_count - w0), 64'd0);
    do_start(1'b0, 1'b1);
    check("ign_start_stop_busy", 64'(bus.busy), 64'h1);
    strobe(32'hD0, 1'b0);
    strobe(32'hD1, 1'b0);
    do_start(1'b1, 1'b0);
    check("ign_start_rec_busy", 64'(bus.busy), 64'h1);
    strobe(32'hD2, 1'b0);
    pulse_stop();
    idle(2);
    check("ign_rec_len", 64'(bus.rec_len), 64'd2);
    check("ign_wrapped", 64'(bus.wrapped), 64'h0);
    check("ign_mem1", 64'(shadow[1]), 64'hD2);

    // Reset in the middle of REC while a write is on the bus
    do_start(1'b0, 1'b0);
    strobe(32'hE0, 1'b0);
    for (int i = 1; i <= 5; i++) strobe(32'hE0 + 32'(i), 1'b0);
    bus.word_valid = 1'b1;
    bus.word_data  = 32'hE6;
    @(posedge clk);
    #1;
    bus.word_valid = 1'b0;
    check("rs_we_before", 64'(bus.mem_we), 64'hF);
    check("rs_addr_before", 64'(bus.mem_addr), 64'd5);
    reset = 1'b1;
    #1;
    check("rs_we", 64'(bus.mem_we), 64'h0);
    check("rs_busy", 64'(bus.busy), 64'h0);
    check("rs_rec_len", 64'(bus.rec_len), 64'h0);
    m_active = 0;
    exp_done_cyc = -1;
    exp_q.delete();
    idle(2);
    reset = 1'b0;
    idle(1);
    do_start(1'b0, 1'b0);
    strobe(32'hF0, 1'b0);
    strobe(32'hF1, 1'b0);
    pulse_stop();
    idle(2);
    check("rs_mem0", 64'(shadow[0]), 64'hF1);
    check("rs_rec_len_after", 64'(bus.rec_len), 64'd1);

    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
